bus_owner_ctrl: RTL and testbench

Sequential ownership controller directly downstream of the 4-device fixed-priority arbiter (req/grant/grant_num/available).
- Converts the arbiter's combinational grant into a locked bus tenure of a per-device programmed burst length.
- While a burst runs, higher-priority requests cannot pre-empt it.
- Reports beat progress, completion and abort per device, and inserts a one-cycle turnaround between tenures.

---
 rtl/bus_owner_ctrl.sv | 140 ++++++++++++++
 tb/tb_bus_owner_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_owner_ctrl.sv
// bus_owner_ctrl: turns the arbiter's combinational grant into a locked,
// fixed-length bus tenure. A captured owner keeps the bus for L+1 beats
// unless it drops its request, and every tenure ends with a one-cycle
// turnaround (GAP) that carries the done/abort pulse.
module bus_owner_ctrl #(
    parameter int N_DEV = 4,
    parameter int NUM_W = 2,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_DEV-1:0]         req,
    input  logic [N_DEV-1:0]         grant,
    input  logic [NUM_W-1:0]         grant_num,
    input  logic                     available,
    input  logic [N_DEV*LEN_W-1:0]   len,
    output logic [N_DEV-1:0]         owner,
    output logic [NUM_W-1:0]         owner_num,
    output logic                     bus_busy,
    output logic                     beat_valid,
    output logic [LEN_W-1:0]         beat_cnt,
    output logic                     last,
    output logic [N_DEV-1:0]         done,
    output logic                     abort
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [N_DEV-1:0]   owner_reg, owner_next;
    logic [NUM_W-1:0]   owner_num_reg, owner_num_next;
    logic [LEN_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [LEN_W-1:0]   len_lat_reg, len_lat_next;
    logic [N_DEV-1:0]   done_reg, done_next;
    logic               abort_reg, abort_next;

    // Capture is driven purely by grant_num; the one-hot grant is redundant
    // with it, so it is folded here only to mark it as deliberately unused.
    logic               unused_grant;
    assign unused_grant = ^grant;

    logic [LEN_W-1:0]   len_field [N_DEV];
    logic [N_DEV-1:0]   grant_dec;
    logic [N_DEV-1:0]   owner_dec;
    logic               in_xfer;
    logic               last_beat;

    // Per-device burst-length slices and one-hot decodes of the two indices.
    generate
        for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
            assign len_field[gi] = len[gi*LEN_W +: LEN_W];
            assign grant_dec[gi] = (grant_num == NUM_W'(gi));
            assign owner_dec[gi] = (owner_num_reg == NUM_W'(gi));
        end
    endgenerate

    assign in_xfer   = (state_reg == S_XFER);
    assign last_beat = in_xfer && (beat_cnt_reg == len_lat_reg);

    assign owner      = owner_reg;
    assign owner_num  = owner_num_reg;
    assign bus_busy   = in_xfer;
    assign beat_valid = in_xfer;
    assign beat_cnt   = beat_cnt_reg;
    assign last       = last_beat;
    assign done       = done_reg;
    assign abort      = abort_reg;

    // State and output registers; reset wins over any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            owner_reg     <= '0;
            owner_num_reg <= '0;
            beat_cnt_reg  <= '0;
            len_lat_reg   <= '0;
            done_reg      <= '0;
            abort_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            owner_num_reg <= owner_num_next;
            beat_cnt_reg  <= beat_cnt_next;
            len_lat_reg   <= len_lat_next;
            done_reg      <= done_next;
            abort_reg     <= abort_next;
        end
    end

    // Next-state logic: capture in IDLE, count beats in XFER, clear in GAP.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        owner_num_next = owner_num_reg;
        beat_cnt_next  = beat_cnt_reg;
        len_lat_next   = len_lat_reg;
        done_next      = done_reg;
        abort_next     = abort_reg;

        case (state_reg)
            S_IDLE: begin
                if (!available) begin
                    state_next     = S_XFER;
                    owner_num_next = grant_num;
                    owner_next     = grant_dec;
                    len_lat_next   = len_field[grant_num];
                    beat_cnt_next  = '0;
                end
            end
            S_XFER: begin
                // Completion is checked first so a request dropped on the
                // final beat still counts as a finished burst.
                if (last_beat) begin
                    state_next = S_GAP;
                    done_next  = owner_dec;
                end else if (!req[owner_num_reg]) begin
                    state_next = S_GAP;
                    abort_next = 1'b1;
                end else begin
                    beat_cnt_next = beat_cnt_reg + LEN_W'(1);
                end
            end
            S_GAP: begin
                state_next    = S_IDLE;
                owner_next    = '0;
                beat_cnt_next = '0;
                done_next     = '0;
                abort_next    = 1'b0;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_owner_ctrl.sv
// tb_bus_owner_ctrl: table-driven directed vectors, hand-written corner
// sequences and a randomized run checked against a tenure-level model.
module tb_bus_owner_ctrl;

    localparam int N_DEV = 4;
    localparam int NUM_W = 2;
    localparam int LEN_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_DEV-1:0]       req;
    logic [N_DEV-1:0]       grant;
    logic [NUM_W-1:0]       grant_num;
    logic                   available;
    logic [N_DEV*LEN_W-1:0] len;
    logic [N_DEV-1:0]       owner;
    logic [NUM_W-1:0]       owner_num;
    logic                   bus_busy;
    logic                   beat_valid;
    logic [LEN_W-1:0]       beat_cnt;
    logic                   last;
    logic [N_DEV-1:0]       done;
    logic                   abort;

    bus_owner_ctrl #(.N_DEV(N_DEV), .NUM_W(NUM_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_num(grant_num),
        .available(available), .len(len), .owner(owner), .owner_num(owner_num),
        .bus_busy(bus_busy), .beat_valid(beat_valid), .beat_cnt(beat_cnt),
        .last(last), .done(done), .abort(abort)
    );

    always #5 clk = ~clk;

    // Observation bundle: {owner, owner_num, busy, beat_valid, cnt, last, done, abort}
    typedef logic [17:0] obs_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic obs_t pk(logic [3:0] ow, logic [1:0] num, logic busy, logic bv,
                                logic [3:0] cnt, logic lst, logic [3:0] dn, logic ab);
        return {ow, num, busy, bv, cnt, lst, dn, ab};
    endfunction

    // Shorthand for legal expectations where beat_valid always equals bus_busy.
    function automatic obs_t o(logic [3:0] ow, logic [1:0] num, logic busy,
                               logic [3:0] cnt, logic lst, logic [3:0] dn, logic ab);
        return pk(ow, num, busy, busy, cnt, lst, dn, ab);
    endfunction

    function automatic string show(obs_t v);
        return $sformatf("owner=%b num=%0d busy=%b bv=%b cnt=%0d last=%b done=%b abort=%b",
                         v[17:14], v[13:12], v[11], v[10], v[9:6], v[5], v[4:1], v[0]);
    endfunction

    task automatic check(string name, obs_t want);
        obs_t got;
        got = pk(owner, owner_num, bus_busy, beat_valid, beat_cnt, last, done, abort);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got {%s} want {%s}", name, show(got), show(want));
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks a tenure as: which device owns the bus, its beat budget, how
    // many beats have gone, and whether we sit in the turnaround cycle and why.
    int  m_dev = 0;
    int  m_budget = 0;
    int  m_beat = 0;
    bit  m_burst = 0;
    bit  m_turn = 0;
    bit  m_finished = 0;
    bit  m_dropped = 0;

    task automatic model_step();
        if (rst) begin
            m_dev = 0; m_beat = 0; m_burst = 0; m_turn = 0;
            m_finished = 0; m_dropped = 0;
        end else if (m_burst) begin
            if (m_beat == m_budget) begin
                m_burst = 0; m_turn = 1; m_finished = 1;
            end else if (!req[m_dev]) begin
                m_burst = 0; m_turn = 1; m_dropped = 1;
            end else begin
                m_beat++;
            end
        end else if (m_turn) begin
            m_turn = 0; m_finished = 0; m_dropped = 0; m_beat = 0;
        end else if (!available) begin
            m_dev    = int'(grant_num);
            m_budget = int'((len >> (LEN_W * m_dev)) & 16'hF);
            m_beat   = 0;
            m_burst  = 1;
        end
    endtask

    function automatic obs_t model_expect();
        logic [3:0] oh;
        oh = 4'(1 << m_dev);
        return pk((m_burst || m_turn) ? oh : 4'b0, 2'(m_dev), m_burst, m_burst,
                  4'(m_beat), m_burst && (m_beat == m_budget),
                  m_finished ? oh : 4'b0, m_dropped);
    endfunction

    // Drive one cycle's inputs, let the edge happen, sample 1 ns later.
    task automatic apply(logic r, logic [3:0] rq, logic [3:0] gr, logic [1:0] gn,
                         logic av, logic [15:0] ln);
        rst = r; req = rq; grant = gr; grant_num = gn; available = av; len = ln;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic [3:0]  rq;
        logic [3:0]  gr;
        logic [1:0]  gn;
        logic        av;
        logic [15:0] ln;
        obs_t        exp;
        string       nm;
    } vec_t;

    vec_t tv[$];

    task automatic add(string nm, logic r, logic [3:0] rq, logic [3:0] gr, logic [1:0] gn,
                       logic av, logic [15:0] ln, obs_t exp);
        vec_t v;
        v.r = r; v.rq = rq; v.gr = gr; v.gn = gn; v.av = av; v.ln = ln; v.exp = exp; v.nm = nm;
        tv.push_back(v);
    endtask

    initial begin
        logic [3:0]  rq;
        logic [3:0]  gr;
        logic [1:0]  gn;
        logic        av;
        logic        r;
        logic [15:0] ln;

        rst = 1'b1; req = '0; grant = '0; grant_num = '0; available = 1'b1; len = '0;

        // 1: reset then idle
        add("t1_reset", 1, 4'b0000, 4'b0000, 0, 1, 16'h0000, o(0, 0, 0, 0, 0, 0, 0));
        add("t1_reset", 1, 4'b0000, 4'b0000, 0, 1, 16'h0000, o(0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            add("t1_idle", 0, 4'b0000, 4'b0000, 0, 1, 16'h0000, o(0, 0, 0, 0, 0, 0, 0));
        // 2: device 2, L=3
        for (int k = 0; k < 4; k++)
            add("t2_beat", 0, 4'b0100, 4'b0100, 2, 0, 16'h0300,
                o(4'b0100, 2, 1, 4'(k), k == 3, 0, 0));
        add("t2_gap",  0, 4'b0000, 4'b0000, 0, 1, 16'h0300, o(4'b0100, 2, 0, 3, 0, 4'b0100, 0));
        add("t2_idle", 0, 4'b0000, 4'b0000, 0, 1, 16'h0300, o(0, 2, 0, 0, 0, 0, 0));
        // 3: device 3, L=5, device 0 requests mid-burst and must wait
        for (int k = 0; k < 3; k++)
            add("t3_beat", 0, 4'b1000, 4'b1000, 3, 0, 16'h5000, o(4'b1000, 3, 1, 4'(k), 0, 0, 0));
        for (int k = 3; k < 6; k++)
            add("t3_nopre", 0, 4'b1001, 4'b0001, 0, 0, 16'h5000,
                o(4'b1000, 3, 1, 4'(k), k == 5, 0, 0));
        add("t3_gap",  0, 4'b1001, 4'b0001, 0, 0, 16'h5000, o(4'b1000, 3, 0, 5, 0, 4'b1000, 0));
        add("t3_idle", 0, 4'b1001, 4'b0001, 0, 0, 16'h5000, o(0, 3, 0, 0, 0, 0, 0));
        add("t3_cap0", 0, 4'b1001, 4'b0001, 0, 0, 16'h5000, o(4'b0001, 0, 1, 0, 1, 0, 0));
        add("t3_gap0", 0, 4'b0000, 4'b0000, 0, 1, 16'h5000, o(4'b0001, 0, 0, 0, 0, 4'b0001, 0));
        add("t3_idl0", 0, 4'b0000, 4'b0000, 0, 1, 16'h5000, o(0, 0, 0, 0, 0, 0, 0));

        foreach (tv[i]) begin
            apply(tv[i].r, tv[i].rq, tv[i].gr, tv[i].gn, tv[i].av, tv[i].ln);
            check(tv[i].nm, tv[i].exp);
            $display("vec %0d %s: %s", i, tv[i].nm, show(tv[i].exp));
        end

        // 4: abort, device 1 with L=7, req dropped while beat_cnt=3
        for (int k = 0; k < 4; k++) begin
            apply(0, 4'b0010, 4'b0010, 1, 0, 16'h0070);
            check("t4_beat", o(4'b0010, 1, 1, 4'(k), 0, 0, 0));
        end
        apply(0, 4'b0000, 4'b0000, 0, 1, 16'h0070);
        check("t4_abort", o(4'b0010, 1, 0, 3, 0, 4'b0000, 1));
        apply(0, 4'b0000, 4'b0000, 0, 1, 16'h0070);
        check("t4_idle", o(0, 1, 0, 0, 0, 0, 0));
        $display("seq t4 abort done");

        // 5: L=0 with req dropped on the only beat -> done wins over abort
        apply(0, 4'b0001, 4'b0001, 0, 0, 16'h0000);
        check("t5_beat", o(4'b0001, 0, 1, 0, 1, 0, 0));
        apply(0, 4'b0000, 4'b0000, 0, 1, 16'h0000);
        check("t5_done", o(4'b0001, 0, 0, 0, 0, 4'b0001, 0));
        apply(0, 4'b0000, 4'b0000, 0, 1, 16'h0000);
        check("t5_idle", o(0, 0, 0, 0, 0, 0, 0));
        $display("seq t5 collision done");

        // 6: reset at beat 2 of a 10-beat burst, then a fresh capture
        for (int k = 0; k < 3; k++) begin
            apply(0, 4'b0100, 4'b0100, 2, 0, 16'h0900);
            check("t6_beat", o(4'b0100, 2, 1, 4'(k), 0, 0, 0));
        end
        apply(1, 4'b0100, 4'b0100, 2, 0, 16'h0900);
        check("t6_reset", o(0, 0, 0, 0, 0, 0, 0));
        apply(0, 4'b0100, 4'b0100, 2, 0, 16'h0900);
        check("t6_recap", o(4'b0100, 2, 1, 0, 0, 0, 0));
        $display("seq t6 reset-mid-burst done");

        // Randomized run against the model, fed by a fixed-priority arbiter (bit 0 wins).
        apply(1, 4'b0000, 4'b0000, 0, 1, 16'h0000);
        rq = '0;
        ln = 16'($urandom);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_DEV; b++)
                if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            if ($urandom_range(15) == 0) ln = 16'($urandom);
            r  = ($urandom_range(299) == 0);
            gr = '0; gn = '0; av = 1'b1;
            for (int b = N_DEV - 1; b >= 0; b--)
                if (rq[b]) begin
                    gr = 4'(1 << b); gn = 2'(b); av = 1'b0;
                end
            if ($urandom_range(63) == 0) begin
                gr = '0; gn = 2'($urandom_range(3)); av = 1'b0;
            end
            apply(r, rq, gr, gn, av, ln);
            check("rand", model_expect());
            if (m_turn)
                $display("tenure dev=%0d beats=%0d %s", m_dev, m_beat + 1,
                         m_finished ? "complete" : "aborted");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
